// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-OpenRAM port-0 controller.
package wb_sram_pkg;

  // Byte address bit where the SRAM word address starts (32-bit words).
  localparam int WORD_LSB = 2;

  // Default SRAM word-address width and the number of upper address bits
  // compared against the base address to decode the 1 KiB window.
  localparam int SRAM_AW = 8;
  localparam int MATCH_W = 32 - SRAM_AW - WORD_LSB;

  // SRAM word address for the default macro geometry.
  typedef logic [SRAM_AW-1:0] word_addr_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } state_t;

endpackage

// File: rtl/wb_sram_rdbuf.sv
// One-entry read buffer (valid, word address, data) in front of the SRAM.
// Only instantiated when WB_SRAM_RDBUF_EN is defined.
module wb_sram_rdbuf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  inval,
  input  logic [ADDR_WIDTH-1:0] inval_addr,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  // Capture every SRAM read; drop the entry when its word is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      addr_reg  <= fill_addr;
      data_reg  <= fill_data;
    end else if (inval && (inval_addr == addr_reg)) begin
      valid_reg <= 1'b0;
    end
  end

  assign hit  = valid_reg && (lookup_addr == addr_reg);
  assign data = data_reg;

endmodule

// File: rtl/wb_sram_port_ctrl.sv
// Wishbone classic slave driving port 0 (read/write) of a 32x256 OpenRAM
// macro. Macro inputs are combinational from the bus; reads capture dout0
// exactly at the end of the cycle after the macro registered the request.
// Optional feature macro: WB_SRAM_RDBUF_EN (one-entry read buffer).
module wb_sram_port_ctrl
  import wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int WIN_LSB = ADDR_WIDTH + WORD_LSB;

  state_t                state_reg, state_next;
  logic                  ack_reg;
  logic [DATA_WIDTH-1:0] dat_reg;

  logic                  hit;
  logic                  idle_hit;
  logic                  wr_accept;
  logic                  buf_hit;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_rd;

  // Byte-offset bits inside a word carry no information for a word port.
  logic unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[WORD_LSB-1:0]};

  assign hit       = wbs_cyc_i && wbs_stb_i &&
                     (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign idle_hit  = (state_reg == IDLE) && hit && !wb_rst_i;
  assign wr_accept = idle_hit && wbs_we_i;
  assign buf_rd    = idle_hit && !wbs_we_i && buf_hit;

  // Macro port fields are a direct remap of the bus request.
  assign sram_addr0  = wbs_adr_i[WIN_LSB-1:WORD_LSB];
  assign sram_wmask0 = wbs_sel_i;
  assign sram_din0   = wbs_dat_i;
  assign sram_web0   = ~wbs_we_i;
  // Select the macro only for a fresh request that the buffer cannot serve.
  assign sram_csb0   = ~(idle_hit && !buf_rd);

`ifdef WB_SRAM_RDBUF_EN
  logic [ADDR_WIDTH-1:0] rd_addr_reg;

  // Remember the word address of an SRAM read so the capture can fill the buffer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_addr_reg <= '0;
    end else if (idle_hit && !wbs_we_i) begin
      rd_addr_reg <= sram_addr0;
    end
  end

  wb_sram_rdbuf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rdbuf (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .fill       (state_reg == RD_WAIT),
    .fill_addr  (rd_addr_reg),
    .fill_data  (sram_dout0),
    .inval      (wr_accept),
    .inval_addr (sram_addr0),
    .lookup_addr(sram_addr0),
    .hit        (buf_hit),
    .data       (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Next-state decode: writes and buffered reads ack next cycle, SRAM reads wait one more.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          if (wbs_we_i || buf_hit) state_next = ACK;
          else                     state_next = RD_WAIT;
        end
      end
      RD_WAIT: state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, registered ack and read-data capture (dout0 only valid at end of RD_WAIT).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      dat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= (state_next == ACK);
      if (state_reg == RD_WAIT) begin
        dat_reg <= sram_dout0;
      end else if (buf_rd) begin
        dat_reg <= buf_data;
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_sram_port_ctrl.sv
// Directed bench for wb_sram_port_ctrl paired with a behavioural OpenRAM
// port-0 model. Read latency expectations follow WB_SRAM_RDBUF_EN.
module tb_wb_sram_port_ctrl;
  import wb_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic        csb, web;
  logic [3:0]  wmask;
  logic [7:0]  addr0;
  logic [31:0] din0, dout0;

  int total = 0;
  int bad   = 0;

`ifdef WB_SRAM_RDBUF_EN
  localparam int RD2_LAT = 1;
  localparam logic RD2_CSB = 1'b1;
`else
  localparam int RD2_LAT = 2;
  localparam logic RD2_CSB = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_sram_port_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_w),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_r),
    .sram_csb0  (csb),
    .sram_web0  (web),
    .sram_wmask0(wmask),
    .sram_addr0 (addr0),
    .sram_din0  (din0),
    .sram_dout0 (dout0)
  );

  // Behavioural macro: inputs registered on posedge, write/read on negedge,
  // dout valid only until the next posedge (poison value afterwards).
  logic [31:0] mem [0:255];
  logic        csb_q = 1'b1, web_q = 1'b1;
  logic [3:0]  wm_q = 4'h0;
  logic [7:0]  a_q = 8'h00;
  logic [31:0] d_q = 32'h0, rd_data = 32'h0;
  int          cyc_cnt = 0;
  int          rd_stamp = -1;

  always @(posedge clk) begin
    csb_q   <= csb;
    web_q   <= web;
    wm_q    <= wmask;
    a_q     <= addr0;
    d_q     <= din0;
    cyc_cnt <= cyc_cnt + 1;
  end

  always @(negedge clk) begin
    if (!csb_q) begin
      if (!web_q) begin
        for (int b = 0; b < 4; b++)
          if (wm_q[b]) mem[a_q][8*b +: 8] <= d_q[8*b +: 8];
      end else begin
        rd_data  <= mem[a_q];
        rd_stamp <= cyc_cnt;
      end
    end
  end

  assign dout0 = (rd_stamp == cyc_cnt) ? rd_data : 32'hDEAD_0BAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One classic bus transfer; reports ack latency, read data and csb samples.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [31:0] rdata,
                          output logic csb_t0, output word_addr_t addr_t0,
                          output logic csb_ack);
    logic got;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = 0; got = 1'b0; rdata = 32'h0; csb_ack = 1'b0;
    @(negedge clk);
    csb_t0 = csb; addr_t0 = addr0;
    while (!got && lat < 10) begin
      if (ack) got = 1'b1;
      else begin
        lat++;
        @(negedge clk);
      end
    end
    if (got) begin
      rdata = dat_r; csb_ack = csb;
    end else begin
      check("ack_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    $display("xfer we=%0b adr=%h sel=%h lat=%0d dat_o=%h", w, a, s, lat, rdata);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        c0, cack;
  word_addr_t  a0;
  int          n_ack, n_csb;
  logic        exp_ack [0:4];
  logic        exp_csb [0:4];

  initial begin
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
    adr = 32'h3000_0010; dat_w = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_csb", {31'd0, csb}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;

    // Basic write then read.
    bus_xfer(1'b1, 32'h3000_0010, 32'hDEADBEEF, 4'hF, lat, rd, c0, a0, cack);
    check("wr_lat", lat, 32'd1);
    check("wr_addr0", {24'd0, a0}, 32'h04);
    check("wr_csb_t0", {31'd0, c0}, 32'd0);
    bus_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("rd_lat", lat, 32'd2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_csb_ack", {31'd0, cack}, 32'd1);

    // Byte masks, dat_o hold across writes, sel=0 write.
    bus_xfer(1'b1, 32'h3000_0014, 32'h11223344, 4'hF, lat, rd, c0, a0, cack);
    check("wr_hold_dat", rd, 32'hDEADBEEF);
    bus_xfer(1'b1, 32'h3000_0014, 32'hAABBCCDD, 4'b0101, lat, rd, c0, a0, cack);
    bus_xfer(1'b1, 32'h3000_0014, 32'hFFFFFFFF, 4'h0, lat, rd, c0, a0, cack);
    check("sel0_lat", lat, 32'd1);
    bus_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("mask_lat", lat, 32'd2);
    check("mask_data", rd, 32'h11BB33DD);

    // Back-to-back writes with stb held high through the ACK cycle.
    exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_csb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0018; dat_w = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack%0d", i), {31'd0, ack}, {31'd0, exp_ack[i]});
      check($sformatf("b2b_csb%0d", i), {31'd0, csb}, {31'd0, exp_csb[i]});
      @(posedge clk); #1;
      if (i == 1) begin adr = 32'h3000_001C; dat_w = 32'h2; end
      if (i == 3) begin cyc = 1'b0; stb = 1'b0; end
    end
    $display("b2b writes done");
    bus_xfer(1'b0, 32'h3000_0018, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("b2b_rd0", rd, 32'h1);
    bus_xfer(1'b0, 32'h3000_001C, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("b2b_rd1", rd, 32'h2);

    // Out-of-window read is ignored.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0400;
    n_ack = 0; n_csb = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack) n_ack++;
      if (!csb) n_csb++;
    end
    check("oow_acks", n_ack, 32'd0);
    check("oow_csb_low", n_csb, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    $display("out-of-window read acks=%0d csb_low=%0d", n_ack, n_csb);

    // Reset pulse while in RD_WAIT.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rstw_csb", {31'd0, csb}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    n_ack = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    check("rstw_acks", n_ack, 32'd0);
    check("rstw_dat", dat_r, 32'd0);
    $display("reset in RD_WAIT acks=%0d dat_o=%h", n_ack, dat_r);
    bus_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("rstw_rd_lat", lat, 32'd2);
    check("rstw_rd_data", rd, 32'hDEADBEEF);

    // Repeated read of one word, then write and re-read.
    bus_xfer(1'b1, 32'h3000_0020, 32'hCAFEF00D, 4'hF, lat, rd, c0, a0, cack);
    bus_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("rep_rd1_lat", lat, 32'd2);
    check("rep_rd1_data", rd, 32'hCAFEF00D);
    bus_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("rep_rd2_lat", lat, RD2_LAT);
    check("rep_rd2_csb", {31'd0, c0}, {31'd0, RD2_CSB});
    check("rep_rd2_data", rd, 32'hCAFEF00D);
    bus_xfer(1'b1, 32'h3000_0020, 32'h0BADC0DE, 4'hF, lat, rd, c0, a0, cack);
    bus_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, lat, rd, c0, a0, cack);
    check("rep_rd3_lat", lat, 32'd2);
    check("rep_rd3_data", rd, 32'h0BADC0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_port_ctrl.md
# wb_sram_port_ctrl

Wishbone classic slave that owns the read/write port (port 0) of one 32x256 OpenRAM SRAM macro and turns bus cycles into the macro's active-low strobe protocol. It sits between the Caravel user-project Wishbone bus and the macro: it drives csb0/web0/wmask0/addr0/din0 and captures dout0. The macro's clk0 is tied to wb_clk_i at the top level.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: byte base address of the 1 KiB window.
- ADDR_WIDTH, 8: SRAM word-address width.
- DATA_WIDTH, 32: data width.
- NUM_WMASKS, 4: byte lanes.

Ports (the clock is the single clock; **reset is synchronous, active-high**):
- wb_clk_i  in  1  clock, also clk0 of the macro.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge, registered.
- wbs_dat_o  out  32  read data, registered.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  4  macro byte write mask.
- sram_addr0  out  8  macro word address.
- sram_din0  out  32  macro write data.
- sram_dout0  in  32  macro read data.

## Operation
- Hit: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
- Requests outside the window are ignored: no ack and no SRAM access. Another slave decodes them.
- Field mapping: sram_addr0 = wbs_adr_i[ADDR_WIDTH+1:2]; sram_wmask0 = wbs_sel_i; sram_din0 = wbs_dat_i; sram_web0 = ~wbs_we_i.
- Macro inputs are combinational from the bus. sram_csb0 is low only when state is IDLE, a hit is present and wb_rst_i = 0; otherwise it is 1.
- FSM states:
  - IDLE: on a write hit, go to ACK. On a read hit, go to RD_WAIT.
  - RD_WAIT: csb0 = 1. At the end of this cycle, wbs_dat_o <= sram_dout0 and wbs_ack_o <= 1. Go to ACK.
  - ACK: wbs_ack_o = 1 for exactly this cycle. The request is ignored even if stb is still high. Go to IDLE.
- A write with wbs_sel_i = 0 is still acked; the macro writes nothing.
- wbs_dat_o holds its last value between reads. It is not updated by writes.

## Timing
- Reset values: state IDLE, wbs_ack_o 0, wbs_dat_o 0, read buffer invalid. sram_csb0 is 1 while wb_rst_i is high.
- Write: request in cycle T0; the macro registers it at the end of T0; ack is high in T1. Latency is 1 cycle. The macro write completes on the negedge inside T1.
- Read: request in T0; the macro registers it at the end of T0. dout0 is valid from the negedge of T1 plus the macro delay until T_HOLD after the end of T1. It is sampled exactly at the end of T1, never later, because dout0 goes X after that. Ack is high in T2. Latency is 2 cycles.
- Maximum throughput is one write per 2 cycles and one read per 3 cycles (an ACK cycle always follows).
- Reset asserted in RD_WAIT or ACK: the next state is IDLE, ack is 0, and no data is captured. A write already registered by the macro is allowed to complete.

## Configuration
- WB_SRAM_RDBUF_EN: one-entry read buffer (valid bit, word address, data).
  - Fill: on every SRAM read capture.
  - Hit: a read hit in IDLE that matches the valid buffered address does not assert csb0. The FSM goes straight to ACK with wbs_dat_o <= buffer data, giving a read latency of 1.
  - Invalidate: any accepted write to the buffered address, and reset.
- Without the macro: the buffer logic is absent and every read takes the 2-cycle path.

## Structure
- Package wb_sram_pkg holds:
  - the state enum (IDLE, RD_WAIT, ACK);
  - localparams WORD_LSB = 2 and the window-match width;
  - a typedef for the word address.
- Sub-module wb_sram_rdbuf holds the buffer. It is instantiated only under WB_SRAM_RDBUF_EN and has fill, invalidate, lookup-address and hit/data outputs.
- The bench pairs the block with the behavioural SRAM model.

## Test plan
- Reset, then write 0xDEADBEEF with sel 4'hF to 0x3000_0010, then read it -> write ack 1 cycle after the request, read ack 2 cycles after the request, wbs_dat_o = 0xDEADBEEF, sram_addr0 = 8'h04.
- Byte mask: write 0x11223344 (sel F), then 0xAABBCCDD (sel 4'b0101) to the same word, then read -> 0x11BB33DD.
- Back-to-back: stb held high across an ack -> exactly one ack per request, and csb0 stays high in the ACK cycle.
- Out of window: read 0x3000_0400 -> no ack and csb0 stays 1 for 10 cycles.
- Reset pulse in RD_WAIT -> ack never asserts, state returns to IDLE, wbs_dat_o = 0, and the next read succeeds.
- With WB_SRAM_RDBUF_EN:
  - Two reads of 0x3000_0020 -> the second acks after 1 cycle with csb0 held high.
  - A write to that word followed by a read -> the read takes 2 cycles and returns the new data.
